// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller and its buffer.
package fetch_pkg;

   localparam int unsigned INSTR_BYTES      = 4;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef enum logic [1:0] {
      RUN  = 2'd0,
      HALT = 2'd1,
      ERR  = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Fetched-instruction buffer: circular FIFO of {pc, instr} entries with flush.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         push,
   input  fetch_entry_t                 push_data,
   input  logic                         pop,
   input  logic                         flush,
   output fetch_entry_t                 head,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   fetch_entry_t  mem [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] cnt;

   function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // Pointers and occupancy; flush discards everything, including a same-cycle push/pop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) wr_ptr <= bump(wr_ptr);
         if (pop)  rd_ptr <= bump(rd_ptr);
         cnt <= cnt + CW'(push) - CW'(pop);
      end
   end

   // Storage carries no reset; the head is only meaningful while count is nonzero.
   always_ff @(posedge clk) begin
      if (push && !flush) mem[wr_ptr] <= push_data;
   end

   assign head  = mem[rd_ptr];
   assign count = cnt;

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: run/halt/error FSM, fetch pc, credit-based issue
// into a small response buffer, and redirect/flush handling.
module instr_fetch_ctrl
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        fetch_en,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [31:0] out_instr,
   output logic        misalign_err
);

   localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned OW = CW + 1;

   fetch_state_t  state_q, state_d;
   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [31:0]   req_pc_q;
   logic          inflight_q;
   logic          err_q, err_d;
   logic          flush;
   logic          push;
   logic          pop;
   logic          credit;
   logic          misaligned;
   logic [CW-1:0] count;
   logic [OW-1:0] occupancy;
   fetch_entry_t  head;
   fetch_entry_t  push_data;

   assign pop        = out_valid & out_ready;
   assign occupancy  = OW'(count) + OW'(inflight_q) - OW'(pop);
   assign credit     = occupancy < OW'(FIFO_DEPTH);
   assign misaligned = redirect_pc[1:0] != 2'b00;

   // Next state, next fetch pc and request issue; any redirect flushes and kills the inflight word.
   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      err_d      = err_q;
      flush      = 1'b0;
      imem_req   = 1'b0;
      case (state_q)
         RUN, HALT: begin
            if (redirect_valid) begin
               flush = 1'b1;
               if (misaligned) begin
                  state_d = ERR;
                  err_d   = 1'b1;
               end else begin
                  fetch_pc_d = redirect_pc;
                  state_d    = fetch_en ? RUN : HALT;
               end
            end else begin
               state_d = fetch_en ? RUN : HALT;
               if (rst_n && state_q == RUN && fetch_en && credit) begin
                  imem_req   = 1'b1;
                  fetch_pc_d = fetch_pc_q + 32'(INSTR_BYTES);
               end
            end
         end
         default: begin
            state_d = ERR;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= RUN;
         fetch_pc_q <= RESET_PC;
         req_pc_q   <= '0;
         inflight_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         inflight_q <= imem_req;
         err_q      <= err_d;
         if (imem_req) req_pc_q <= fetch_pc_q;
      end
   end

   assign push      = inflight_q & ~flush;
   assign push_data = '{pc: req_pc_q, instr: imem_rdata};

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .flush     (flush),
      .head      (head),
      .count     (count)
   );

   assign imem_addr    = fetch_pc_q;
   assign out_valid    = (count != '0) && (state_q != ERR);
   assign out_pc       = out_valid ? head.pc    : '0;
   assign out_instr    = out_valid ? head.instr : '0;
   assign misalign_err = err_q;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: directed scenarios plus random traffic, checked by a
// transaction-level model of the expected pc stream.
module tb_instr_fetch_ctrl;

   localparam int          DEPTH  = 3;
   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        fetch_en = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
   logic        misalign_err;

   int checks = 0;
   int errors = 0;
   int accepted = 0;

   instr_fetch_ctrl #(
      .RESET_PC   (RST_PC),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .fetch_en       (fetch_en),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_pc         (out_pc),
      .out_instr      (out_instr),
      .misalign_err   (misalign_err)
   );

   always #5 clk = ~clk;

   // Memory image: every word is a fixed hash of its address.
   function automatic logic [31:0] word_at(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
   endfunction

   logic [31:0] mem_addr_q = '0;
   always @(posedge clk) mem_addr_q <= imem_addr;
   assign imem_rdata = word_at(mem_addr_q);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Model: decode must see the sequential pc stream from reset, restarting at each
   // aligned redirect target; requests follow the same rule on the memory side.
   logic [31:0] exp_q[$];
   logic [31:0] next_pc, req_pc_m, pop_pc, held_pc, held_instr;
   int          outst;
   bit          err_m, stall_prev;

   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         next_pc    = RST_PC;
         req_pc_m   = RST_PC;
         outst      = 0;
         err_m      = 1'b0;
         stall_prev = 1'b0;
      end else begin
         while (exp_q.size() < 4) begin
            exp_q.push_back(next_pc);
            next_pc = next_pc + 32'd4;
         end
         if (stall_prev) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_pc", out_pc, held_pc);
            chk("hold_instr", out_instr, held_instr);
         end
         if (err_m) begin
            chk("err_req", 32'(imem_req), 32'd0);
            chk("err_valid", 32'(out_valid), 32'd0);
            chk("err_flag", 32'(misalign_err), 32'd1);
         end else begin
            chk("err_flag_clear", 32'(misalign_err), 32'd0);
            if (imem_req) begin
               chk("req_gate", 32'({redirect_valid, fetch_en}), 32'd1);
               chk("req_addr", imem_addr, req_pc_m);
               req_pc_m = req_pc_m + 32'd4;
               outst++;
            end
            if (out_valid && out_ready) begin
               pop_pc = exp_q.pop_front();
               chk("out_pc", out_pc, pop_pc);
               chk("out_instr", out_instr, word_at(pop_pc));
               outst--;
               accepted++;
            end
            chk("credit_bound", 32'(outst <= DEPTH), 32'd1);
            if (redirect_valid) begin
               if (redirect_pc[1:0] != 2'b00) begin
                  err_m = 1'b1;
               end else begin
                  exp_q.delete();
                  next_pc  = redirect_pc;
                  req_pc_m = redirect_pc;
                  outst    = 0;
               end
            end
         end
         stall_prev = out_valid && !out_ready && !redirect_valid;
         held_pc    = out_pc;
         held_instr = out_instr;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   logic [31:0] r;

   initial begin
      rst_n = 1'b0; fetch_en = 1'b1; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_req", 32'(imem_req), 32'd0);
      chk("rst_pc", out_pc, 32'd0);
      chk("rst_instr", out_instr, 32'd0);
      chk("rst_err", 32'(misalign_err), 32'd0);

      // Streaming from reset: one request per cycle, first output two cycles later.
      cyc(); rst_n = 1'b1;
      for (int k = 0; k < 10; k++) begin
         if (k > 0) cyc();
         #1;
         chk("a_req", 32'(imem_req), 32'd1);
         chk("a_addr", imem_addr, RST_PC + 32'(4 * k));
         chk("a_valid", 32'(out_valid), 32'(k >= 2));
         if (k >= 2) chk("a_pc", out_pc, RST_PC + 32'(4 * (k - 2)));
      end

      // Backpressure: buffer fills, requests stop, head holds.
      cyc(); out_ready = 1'b0;
      repeat (4) cyc();
      #1;
      chk("s_req_stop", 32'(imem_req), 32'd0);
      chk("s_valid", 32'(out_valid), 32'd1);
      cyc(); out_ready = 1'b1;
      repeat (10) cyc();

      // Redirect with two buffered entries and one inflight.
      rst_n = 1'b0;
      cyc(); rst_n = 1'b1; out_ready = 1'b0;
      cyc(); cyc(); cyc();
      redirect_valid = 1'b1; redirect_pc = 32'h0000_0040;
      #1;
      chk("b_valid_before", 32'(out_valid), 32'd1);
      chk("b_req_suppr", 32'(imem_req), 32'd0);
      cyc(); redirect_valid = 1'b0; out_ready = 1'b1;
      #1;
      chk("b_flushed", 32'(out_valid), 32'd0);
      chk("b_req_tgt", 32'(imem_req), 32'd1);
      chk("b_addr_tgt", imem_addr, 32'h0000_0040);
      cyc(); cyc();
      #1;
      chk("b_first_valid", 32'(out_valid), 32'd1);
      chk("b_first_pc", out_pc, 32'h0000_0040);
      repeat (4) cyc();

      // Address wrap at the top of the address space.
      redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
      cyc(); redirect_valid = 1'b0;
      cyc(); cyc();
      #1; chk("w_pc0", out_pc, 32'hFFFF_FFF8);
      cyc(); #1; chk("w_pc1", out_pc, 32'hFFFF_FFFC);
      cyc(); #1; chk("w_pc2", out_pc, 32'h0000_0000);
      repeat (3) cyc();

      // Halt mid-stream: no requests, buffer drains; resume continues sequentially.
      fetch_en = 1'b0;
      repeat (5) cyc();
      #1;
      chk("h_req", 32'(imem_req), 32'd0);
      chk("h_drained", 32'(out_valid), 32'd0);
      cyc(); fetch_en = 1'b1;
      repeat (8) cyc();

      // Random traffic with aligned redirects, some combined with halt.
      for (int i = 0; i < 600; i++) begin
         cyc();
         r = $urandom();
         out_ready      = (r[1:0] != 2'b00);
         fetch_en       = (r[4:2] != 3'b000);
         redirect_valid = (r[8:5] == 4'b0000);
         redirect_pc    = r[9] ? (32'hFFFF_FFF0 | ($urandom() & 32'h0000_000C))
                               : ($urandom() & 32'h0000_FFFC);
      end
      cyc(); redirect_valid = 1'b0; fetch_en = 1'b1; out_ready = 1'b1;
      repeat (6) cyc();

      // Misaligned redirect: sticky error until reset.
      redirect_valid = 1'b1; redirect_pc = 32'h0000_0042;
      cyc(); redirect_valid = 1'b0;
      #1;
      chk("m_flag", 32'(misalign_err), 32'd1);
      chk("m_req", 32'(imem_req), 32'd0);
      chk("m_valid", 32'(out_valid), 32'd0);
      for (int i = 0; i < 8; i++) begin
         cyc();
         r = $urandom();
         out_ready      = r[0];
         redirect_valid = r[1];
         redirect_pc    = r & 32'h0000_FFFC;
      end
      cyc(); redirect_valid = 1'b0; rst_n = 1'b0;
      #1;
      chk("m_rst_clear", 32'(misalign_err), 32'd0);
      cyc(); rst_n = 1'b1; out_ready = 1'b1; fetch_en = 1'b1;
      repeat (10) cyc();

      // Asynchronous reset mid-cycle discards everything at once.
      @(posedge clk);
      #3;
      chk("x_valid_before", 32'(out_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("x_valid", 32'(out_valid), 32'd0);
      chk("x_req", 32'(imem_req), 32'd0);
      chk("x_pc", out_pc, 32'd0);
      cyc(); rst_n = 1'b1;
      repeat (5) cyc();

      chk("progress", 32'(accepted > 150), 32'd1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/instr_fetch_ctrl.md
INSTR_FETCH_CTRL -- requirements
Module: instr_fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the byte address of the first fetch after reset.
REQ-002 Parameter FIFO_DEPTH, default 2, is the number of fetched-instruction buffer entries (legal values 2..8).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 fetch_en  input  1  1 allows new fetches; 0 halts issue.
REQ-006 redirect_valid  input  1  1 = branch/jump redirect this cycle.
REQ-007 redirect_pc  input  32  redirect target byte address.
REQ-008 imem_req  output  1  read request to instruction memory this cycle.
REQ-009 imem_addr  output  32  word-aligned byte address of the request.
REQ-010 imem_rdata  input  32  little-endian instruction word, valid the cycle after imem_req.
REQ-011 out_valid  output  1  buffer head holds a valid instruction.
REQ-012 out_ready  input  1  decode accepts the head this cycle.
REQ-013 out_pc  output  32  byte address of the head instruction.
REQ-014 out_instr  output  32  head instruction word.
REQ-015 misalign_err  output  1  sticky: redirect_pc[1:0] was nonzero.

Function
REQ-016 FSM states are RUN, HALT and ERR. RUN->HALT when fetch_en=0. HALT->RUN when fetch_en=1. RUN/HALT->ERR on a misaligned redirect. ERR is left only by reset.
REQ-017 The block shall assert imem_req only in RUN with fetch_en=1 and (count - pop + inflight) < FIFO_DEPTH. Here pop = out_valid & out_ready, and inflight = the imem_req registered from the previous cycle.
REQ-018 imem_addr shall equal fetch_pc. fetch_pc shall advance by 4 on each issued request, wrapping modulo 2^32 (32'hFFFF_FFFC -> 0).
REQ-019 The block shall write the response (imem_rdata, its request address) into the FIFO at the end of the cycle after issue, unless it was killed.
REQ-020 Latency from request to out_valid shall be 2 cycles. With out_ready held high, sustained throughput shall be 1 instruction per cycle.
REQ-021 out_pc and out_instr shall hold stable while out_valid=1 and out_ready=0.
REQ-022 The FIFO shall never overflow. The credit rule of REQ-017 shall guarantee this, including when one push and one pop occur in the same cycle.
REQ-023 An aligned redirect_valid shall, in the same cycle, flush all FIFO entries, mark the inflight response killed, suppress imem_req, and load fetch_pc <= redirect_pc. The first request to the target issues the next cycle.
REQ-024 When redirect_valid and pop coincide, the redirect shall win: the FIFO is flushed, and the popped entry counts as consumed by decode.
REQ-025 When redirect_valid and fetch_en=0 coincide, the block shall update fetch_pc and enter HALT with no request issued.
REQ-026 A misaligned redirect (redirect_pc[1:0]!=0) shall set misalign_err, flush the FIFO, kill the inflight response, and enter ERR. In ERR, imem_req and out_valid shall be 0.
REQ-027 In HALT, the block shall complete an inflight response into the FIFO and let decode drain the FIFO normally.

Reset
REQ-028 While rst_n=0: state=RUN, fetch_pc=RESET_PC, FIFO empty, inflight=0, misalign_err=0, out_valid=0, imem_req=0. out_pc and out_instr shall read 0.
REQ-029 If fetch_en=1, the first request (address RESET_PC) shall issue in the first cycle after rst_n rises.
REQ-030 Reset asserted mid-operation shall discard all buffered and inflight data immediately, without waiting for a clock edge.

Structure
REQ-031 Package fetch_pkg shall hold the state enum (RUN, HALT, ERR), INSTR_BYTES=4 and the default RESET_PC.
REQ-032 Sub-module fetch_fifo (parameterised depth, 64-bit entries {pc, instr}, push/pop/flush, count output) shall hold the buffer. The controller FSM, fetch_pc and credit logic shall live in instr_fetch_ctrl.

Verification
REQ-033 Reset release, fetch_en=1, out_ready=1, memory preloaded -> imem_addr 0,4,8,... on consecutive cycles; out_valid from cycle 2; out_pc 0,4,8 with matching words.
REQ-034 out_ready=0 for 5 cycles -> at most FIFO_DEPTH entries buffered, imem_req drops, head stable; out_ready=1 -> stream resumes with no lost or duplicated pc.
REQ-035 Redirect to 32'h0000_0040 while 2 entries buffered and 1 inflight -> next out_pc is 0x40; old entries and the inflight word are never presented.
REQ-036 Redirect to 32'h0000_0042 -> misalign_err=1, imem_req=0 and out_valid=0 until reset; reset clears misalign_err.
REQ-037 Redirect to 32'hFFFF_FFF8 -> out_pc FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-038 fetch_en=0 mid-stream -> no new requests, FIFO drains; fetch_en=1 -> resumes at the next sequential pc.
